// File: rtl/temp_pkg.sv
// Shared constants and types for the temperature averaging and display stage.
package temp_pkg;

  localparam logic [1:0] MODE_AVG_C = 2'b00;
  localparam logic [1:0] MODE_AVG_F = 2'b01;
  localparam logic [1:0] MODE_MIN_C = 2'b10;
  localparam logic [1:0] MODE_MAX_C = 2'b11;

  // F = C * 9/5 + 32 evaluated on 1/16 degC units: 115/1024 ~= 9/80
  localparam int C2F_MUL  = 115;
  localparam int C2F_RND  = 512;
  localparam int C2F_SHR  = 10;
  localparam int F_OFFSET = 32;

  typedef logic [0:0] fill_state_t;
  localparam fill_state_t FILL_EMPTY = 1'b0;
  localparam fill_state_t FILL_RUN   = 1'b1;

endpackage

// File: rtl/temp_avg_ring.sv
// Power-of-two moving average over raw samples; emits the average (1/16 degC)
// two cycles after the sample is accepted.
module temp_avg_ring
  import temp_pkg::*;
#(
  parameter int unsigned TEMP_W   = 13,
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_valid_i,
  input  logic signed [TEMP_W-1:0] temp_raw_i,
  input  logic                     flush_i,
  output logic                     avg_valid_o,
  output logic signed [TEMP_W-1:0] avg16_o
);

  localparam int unsigned N  = 1 << AVG_LOG2;
  localparam int unsigned SW = TEMP_W + AVG_LOG2;
  localparam int unsigned PW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);

  fill_state_t              state_q, state_d;
  logic signed [TEMP_W-1:0] ring_q [N];
  logic [PW-1:0]            ptr_q, ptr_d;
  logic signed [SW-1:0]     sum_q, sum_d;
  logic signed [SW-1:0]     new_ext, old_ext;
  logic                     sum_vld_q, avg_valid_q;
  logic signed [TEMP_W-1:0] avg16_q;
  logic                     first;

  always_comb begin
    new_ext = temp_raw_i;
    old_ext = ring_q[ptr_q];
    // A sample arriving with flush is the first sample of a fresh window.
    first   = sample_valid_i && (flush_i || (state_q == FILL_EMPTY));
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    if (first) begin
      state_d = FILL_RUN;
      ptr_d   = '0;
      sum_d   = new_ext <<< AVG_LOG2;
    end else if (flush_i) begin
      state_d = FILL_EMPTY;
    end else if (sample_valid_i) begin
      sum_d = sum_q + new_ext - old_ext;
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FILL_EMPTY;
      ptr_q       <= '0;
      sum_q       <= '0;
      sum_vld_q   <= 1'b0;
      avg_valid_q <= 1'b0;
      avg16_q     <= '0;
      for (int unsigned i = 0; i < N; i++) ring_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      sum_vld_q   <= sample_valid_i;
      avg_valid_q <= sum_vld_q;
      if (sum_vld_q) avg16_q <= TEMP_W'(sum_q >>> AVG_LOG2);
      if (first) begin
        for (int unsigned i = 0; i < N; i++) ring_q[i] <= temp_raw_i;
      end else if (sample_valid_i) begin
        ring_q[ptr_q] <= temp_raw_i;
      end
    end
  end

  assign avg_valid_o = avg_valid_q;
  assign avg16_o     = avg16_q;

endmodule

// File: rtl/temp_monitor.sv
// Averaged temperature in C/F with min/max tracking, hysteretic alarms and a
// mode-selected display value; one sample per cycle, 3-cycle latency.
module temp_monitor
  import temp_pkg::*;
#(
  parameter int unsigned TEMP_W   = 13,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned OUT_W    = 10,
  parameter int          HI_C     = 30,
  parameter int          LO_C     = 10,
  parameter int          HYST     = 2
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic signed [TEMP_W-1:0] temp_raw,
  input  logic                    flush,
  input  logic                    clear_minmax,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] avg_c,
  output logic signed [OUT_W-1:0] avg_f,
  output logic signed [OUT_W-1:0] min_c,
  output logic signed [OUT_W-1:0] max_c,
  output logic                    alarm_hi,
  output logic                    alarm_lo,
  output logic signed [OUT_W-1:0] disp_value,
  output logic                    disp_is_f
);

  localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(1 << (OUT_W - 1));

  function automatic logic signed [OUT_W-1:0] sat(input int v);
    if (v > OUT_MAX) return OUT_W'(OUT_MAX);
    if (v < OUT_MIN) return OUT_W'(OUT_MIN);
    return OUT_W'(v);
  endfunction

  logic                     avg_vld;
  logic signed [TEMP_W-1:0] avg16;
  int                       avg_i;
  logic signed [OUT_W-1:0]  c_new, f_new;

  logic                     valid_q;
  logic signed [OUT_W-1:0]  avg_c_q, avg_c_d, avg_f_q, avg_f_d;
  logic signed [OUT_W-1:0]  min_q, min_d, max_q, max_d;
  logic                     mmv_q, mmv_d;
  logic                     hi_q, hi_d, lo_q, lo_d;
  logic signed [OUT_W-1:0]  disp_q, disp_d;
  logic                     is_f_q, is_f_d;

  temp_avg_ring #(
    .TEMP_W   (TEMP_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_ring (
    .clk_i          (clk_100MHz),
    .rst_i          (reset),
    .sample_valid_i (sample_valid),
    .temp_raw_i     (temp_raw),
    .flush_i        (flush),
    .avg_valid_o    (avg_vld),
    .avg16_o        (avg16)
  );

  always_comb begin
    avg_i = int'(avg16);
    c_new = sat(avg_i >>> 4);
    f_new = sat(((avg_i * C2F_MUL + C2F_RND) >>> C2F_SHR) + F_OFFSET);

    avg_c_d = avg_c_q;
    avg_f_d = avg_f_q;
    min_d   = min_q;
    max_d   = max_q;
    mmv_d   = mmv_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (avg_vld) begin
      avg_c_d = c_new;
      avg_f_d = f_new;
      // A clear landing on a result reseeds min/max from that result.
      if (!mmv_q || clear_minmax) begin
        min_d = c_new;
        max_d = c_new;
        mmv_d = 1'b1;
      end else begin
        if (c_new < min_q) min_d = c_new;
        if (c_new > max_q) max_d = c_new;
      end
      if (c_new >= HI_C)             hi_d = 1'b1;
      else if (c_new <= HI_C - HYST) hi_d = 1'b0;
      if (c_new <= LO_C)             lo_d = 1'b1;
      else if (c_new >= LO_C + HYST) lo_d = 1'b0;
    end else if (clear_minmax) begin
      mmv_d = 1'b0;
    end

    disp_d = '0;
    is_f_d = 1'b0;
    unique case (mode)
      MODE_AVG_C: disp_d = avg_c_q;
      MODE_AVG_F: begin
        disp_d = avg_f_q;
        is_f_d = 1'b1;
      end
      MODE_MIN_C: disp_d = mmv_q ? min_q : '0;
      MODE_MAX_C: disp_d = mmv_q ? max_q : '0;
      default:    disp_d = '0;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      avg_c_q <= '0;
      avg_f_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
      mmv_q   <= 1'b0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      disp_q  <= '0;
      is_f_q  <= 1'b0;
    end else begin
      valid_q <= avg_vld;
      avg_c_q <= avg_c_d;
      avg_f_q <= avg_f_d;
      min_q   <= min_d;
      max_q   <= max_d;
      mmv_q   <= mmv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      disp_q  <= disp_d;
      is_f_q  <= is_f_d;
    end
  end

  assign out_valid  = valid_q;
  assign avg_c      = avg_c_q;
  assign avg_f      = avg_f_q;
  assign min_c      = min_q;
  assign max_c      = max_q;
  assign alarm_hi   = hi_q;
  assign alarm_lo   = lo_q;
  assign disp_value = disp_q;
  assign disp_is_f  = is_f_q;

endmodule

// File: tb/tb_temp_monitor.sv
// Bench for temp_monitor: arithmetic reference model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_temp_monitor;

  localparam int TEMP_W = 13;
  localparam int OUT_W  = 10;
  localparam int N      = 8;
  localparam int HI     = 30;
  localparam int LO     = 10;
  localparam int HY     = 2;

  logic                     clk_100MHz = 1'b0;
  logic                     reset = 1'b1;
  logic                     sample_valid = 1'b0;
  logic signed [TEMP_W-1:0] temp_raw = '0;
  logic                     flush = 1'b0;
  logic                     clear_minmax = 1'b0;
  logic [1:0]               mode = 2'b00;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  avg_c, avg_f, min_c, max_c, disp_value;
  logic                     alarm_hi, alarm_lo, disp_is_f;

  int checks = 0;
  int failures = 0;

  temp_monitor dut (
    .clk_100MHz   (clk_100MHz),
    .reset        (reset),
    .sample_valid (sample_valid),
    .temp_raw     (temp_raw),
    .flush        (flush),
    .clear_minmax (clear_minmax),
    .mode         (mode),
    .out_valid    (out_valid),
    .avg_c        (avg_c),
    .avg_f        (avg_f),
    .min_c        (min_c),
    .max_c        (max_c),
    .alarm_hi     (alarm_hi),
    .alarm_lo     (alarm_lo),
    .disp_value   (disp_value),
    .disp_is_f    (disp_is_f)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int c;
    int f;
  } res_t;

  int   hist[$];
  res_t pend[$];
  int   ncyc = 0;
  int   m_valid, m_c, m_f, m_min, m_max, m_mmv, m_hi, m_lo, m_disp, m_isf;

  function automatic int floor_div(input int a, input int b);
    int q = a / b;
    if ((a % b != 0) && (a < 0)) q--;
    return q;
  endfunction

  function automatic int clamp(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    pend.delete();
    m_valid = 0; m_c = 0; m_f = 0; m_min = 0; m_max = 0;
    m_mmv = 0; m_hi = 0; m_lo = 0; m_disp = 0; m_isf = 0;
  endtask

  task automatic model_step();
    int   s, k, idx, a16, n_disp, n_isf;
    res_t r;
    n_isf = 0;
    case (mode)
      2'b00: n_disp = m_c;
      2'b01: begin n_disp = m_f; n_isf = 1; end
      2'b10: n_disp = m_mmv ? m_min : 0;
      default: n_disp = m_mmv ? m_max : 0;
    endcase
    m_valid = 0;
    if (pend.size() > 0 && pend[0].due == ncyc + 1) begin
      r = pend.pop_front();
      m_valid = 1;
      m_c = r.c;
      m_f = r.f;
      if (!m_mmv || clear_minmax) begin
        m_min = r.c; m_max = r.c; m_mmv = 1;
      end else begin
        if (r.c < m_min) m_min = r.c;
        if (r.c > m_max) m_max = r.c;
      end
      if (r.c >= HI) m_hi = 1; else if (r.c <= HI - HY) m_hi = 0;
      if (r.c <= LO) m_lo = 1; else if (r.c >= LO + HY) m_lo = 0;
    end else if (clear_minmax) begin
      m_mmv = 0;
    end
    m_disp = n_disp;
    m_isf  = n_isf;
    if (flush) hist.delete();
    if (sample_valid) begin
      hist.push_back(int'(temp_raw));
      // Window of the last N samples, padded with the first sample since flush.
      s = 0;
      k = hist.size();
      for (int i = 0; i < N; i++) begin
        idx = k - 1 - i;
        s += (idx >= 0) ? hist[idx] : hist[0];
      end
      a16 = floor_div(s, N);
      r.due = ncyc + 3;
      r.c   = clamp(floor_div(a16, 16));
      r.f   = clamp(floor_div(a16 * 115 + 512, 1024) + 32);
      pend.push_back(r);
      while (hist.size() > N) void'(hist.pop_front());
    end
    ncyc++;
  endtask

  always @(negedge clk_100MHz) begin
    if (reset) model_reset();
    chk("cmp out_valid", out_valid, m_valid);
    chk("cmp avg_c", avg_c, m_c);
    chk("cmp avg_f", avg_f, m_f);
    chk("cmp min_c", min_c, m_min);
    chk("cmp max_c", max_c, m_max);
    chk("cmp alarm_hi", alarm_hi, m_hi);
    chk("cmp alarm_lo", alarm_lo, m_lo);
    chk("cmp disp_value", disp_value, m_disp);
    chk("cmp disp_is_f", disp_is_f, m_isf);
    if (!reset) model_step();
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic run_sample(input int raw, input bit fl, input int ec, input int ef,
                            input int emin, input int emax, input int ehi, input int elo,
                            input string tag);
    int lat = 0;
    temp_raw     = TEMP_W'(raw);
    flush        = fl;
    sample_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        sample_valid = 1'b0;
        flush        = 1'b0;
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, lat, 3);
    chk({tag, " avg_c"}, avg_c, ec);
    chk({tag, " avg_f"}, avg_f, ef);
    chk({tag, " min_c"}, min_c, emin);
    chk({tag, " max_c"}, max_c, emax);
    chk({tag, " alarm_hi"}, alarm_hi, ehi);
    chk({tag, " alarm_lo"}, alarm_lo, elo);
  endtask

  int tbl [10] = '{400, 800, -80, 1200, 0, 400, 400, 400, 400, 400};

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset out_valid", out_valid, 0);
    chk("reset avg_c", avg_c, 0);
    chk("reset disp_value", disp_value, 0);
    chk("reset alarm_hi", alarm_hi, 0);

    run_sample(400, 0, 25, 77, 25, 25, 0, 0, "s400");
    run_sample(1600, 0, 34, 94, 25, 34, 1, 0, "s1600");
    run_sample(480, 1, 30, 86, 25, 34, 1, 0, "hyst30");
    run_sample(464, 1, 29, 84, 25, 34, 1, 0, "hyst29");
    run_sample(448, 1, 28, 82, 25, 34, 0, 0, "hyst28");
    run_sample(-640, 1, -40, -40, -40, 34, 0, 1, "m40");

    mode = 2'b01;
    tick();
    chk("mode F disp_value", disp_value, -40);
    chk("mode F disp_is_f", disp_is_f, 1);
    mode = 2'b10;
    tick();
    chk("mode min disp_value", disp_value, -40);
    mode = 2'b11;
    tick();
    chk("mode max disp_value", disp_value, 34);
    mode = 2'b00;
    tick();

    // Back-to-back samples on a ring full of -640.
    sample_valid = 1'b1;
    temp_raw = TEMP_W'(160);
    tick();
    temp_raw = TEMP_W'(320);
    tick();
    temp_raw = TEMP_W'(480);
    tick();
    sample_valid = 1'b0;
    chk("b2b ov0", out_valid, 1);
    chk("b2b c0", avg_c, -34);
    tick();
    chk("b2b ov1", out_valid, 1);
    chk("b2b c1", avg_c, -27);
    tick();
    chk("b2b ov2", out_valid, 1);
    chk("b2b c2", avg_c, -18);
    tick();
    chk("b2b ov3", out_valid, 0);

    // Ten consecutive samples wrap the write pointer.
    for (int i = 0; i < 10; i++) begin
      temp_raw = TEMP_W'(tbl[i]);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    tick();
    tick();
    chk("wrap out_valid", out_valid, 1);
    chk("wrap avg_c", avg_c, 24);
    chk("wrap avg_f", avg_f, 76);
    tick();

    run_sample(4095, 1, 255, 492, -40, 255, 1, 0, "maxraw");
    run_sample(-4096, 1, -256, -428, -256, 255, 0, 1, "minraw");

    // Reset one cycle after a sample: that sample never emerges.
    temp_raw = TEMP_W'(800);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("midreset out_valid", out_valid, 0);
    chk("midreset avg_c", avg_c, 0);
    chk("midreset min_c", min_c, 0);
    chk("midreset alarm_lo", alarm_lo, 0);
    reset = 1'b0;
    tick();
    clear_minmax = 1'b1;
    tick();
    clear_minmax = 1'b0;
    run_sample(160, 0, 10, 50, 10, 10, 0, 1, "s160");
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temp_monitor.md
Name: temp_monitor

Overview:
- Parametrised processing stage between the I2C temperature master and the 7-segment/LED display logic.
- Takes raw signed ADT7420-format samples (1 LSB = 1/16 °C) and applies a power-of-two moving average.
- Produces averaged Celsius and Fahrenheit, tracks min/max, and raises hi/lo alarms with hysteresis.
- Selects one of four display quantities by mode. Fully pipelined: accepts a sample every cycle.

Parameters:
TEMP_W, 13, raw sample width, signed two's complement, 1/16 °C per LSB
AVG_LOG2, 3, moving-average depth N = 2^AVG_LOG2 (0 = no averaging)
OUT_W, 10, signed width of all integer-degree outputs
HI_C, 30, high alarm set threshold, °C
LO_C, 10, low alarm set threshold, °C
HYST, 2, alarm hysteresis, °C

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_valid  in  1  one-cycle strobe, temp_raw valid
temp_raw  in  TEMP_W  raw signed sample
flush  in  1  pulse: empty average buffer
clear_minmax  in  1  pulse: invalidate min/max
mode  in  2  00 avg C, 01 avg F, 10 min C, 11 max C
out_valid  out  1  one-cycle strobe, results updated
avg_c  out  OUT_W  averaged temperature, integer °C
avg_f  out  OUT_W  averaged temperature, integer °F
min_c  out  OUT_W  minimum avg_c since clear
max_c  out  OUT_W  maximum avg_c since clear
alarm_hi  out  1  high alarm
alarm_lo  out  1  low alarm
disp_value  out  OUT_W  mode-selected value
disp_is_f  out  1  1 when disp_value is °F

Behaviour:
- Clock and reset: one clock, clk_100MHz. reset is asynchronous and active-high. It zeroes every output and register, sets the fill state to EMPTY and min/max to INVALID, and kills in-flight pipeline strobes. Reset mid-pipeline: no out_valid is produced for that sample.
- Fill FSM, EMPTY -> RUN:
  - In EMPTY, the first accepted sample loads all N ring entries with that sample and sets sum = sample << AVG_LOG2, then moves to RUN.
  - In RUN, each sample overwrites the oldest entry (write pointer wraps mod N) and sets sum += new - oldest.
  - The sum register is TEMP_W+AVG_LOG2 bits signed.
  - flush returns the FSM to EMPTY. If flush and sample_valid are asserted in the same cycle, the sample is treated as the first after the flush.
- Pipeline, with S0 = the cycle sample_valid is high:
  - S1: sum updated.
  - S2: avg16 = sum >>> AVG_LOG2 (floor); c = avg16 >>> 4 (floor); f = ((avg16*115 + 512) >>> 10) + 32.
  - S3: outputs registered and out_valid pulses. Latency is exactly 3 cycles, and back-to-back samples give back-to-back out_valid.
- Saturation: c and f saturate to the signed OUT_W range.
- Min/max:
  - Updated only on out_valid.
  - INVALID -> VALID on the first result: min_c = max_c = avg_c.
  - In VALID: min_c = min(min_c, avg_c), max_c = max(max_c, avg_c).
  - clear_minmax returns to INVALID; min_c/max_c hold their old values until the next result.
  - If clear_minmax coincides with an S3 result, that result reinitialises both.
- Alarms (evaluated on out_valid with the new avg_c):
  - alarm_hi sets when avg_c >= HI_C and clears when avg_c <= HI_C-HYST; otherwise it holds.
  - alarm_lo sets when avg_c <= LO_C and clears when avg_c >= LO_C+HYST; otherwise it holds.
  - flush does not clear alarms.
- Display: disp_value/disp_is_f are registered every cycle from mode and the current output registers, so a mode change is visible 1 cycle later. In modes 10/11 while min/max is INVALID, disp_value = 0.

Decomposition:
- Package temp_pkg:
  - mode encodings MODE_AVG_C/MODE_AVG_F/MODE_MIN_C/MODE_MAX_C
  - C2F constants: C2F_MUL = 115, C2F_RND = 512, C2F_SHR = 10, F_OFFSET = 32
  - fill FSM state type
- One sub-module, temp_avg_ring: the ring buffer, write pointer, fill FSM and running sum; outputs avg16 with a valid strobe.
- C/F conversion, min/max, alarms and display select live in temp_monitor.

Test Plan:
- Defaults, after reset, sample 400 (25.0 °C) -> out_valid exactly 3 cycles later; avg_c = 25, avg_f = 77, min = max = 25, no alarms.
- Then sample 1600 -> sum 4400, avg16 550; avg_c = 34, avg_f = 94, min_c = 25, max_c = 34, alarm_hi = 1.
- Hysteresis: flush, then feed constant averages of 30, 29, 28 °C (raw 480, 464, 448, each after flush) -> alarm_hi = 1, 1, 0.
- flush, sample -640 (-40 °C) -> avg_c = -40, avg_f = -40, alarm_lo = 1; mode = 01 -> next cycle disp_value = -40, disp_is_f = 1.
- Three sample_valid on consecutive cycles -> three consecutive out_valid pulses. Ring pointer wraps after 8 samples, and sum equals the software model.
- Assert reset one cycle after sample_valid -> no out_valid, all outputs 0. clear_minmax then sample 160 -> min_c = max_c = 10, alarm_lo = 1.
